// File: rtl/sfr_bank_if.sv
// sfr_bank_if: CPU byte/bit access and hardware flag update bus for the SFR bank
interface sfr_bank_if;
  logic       cpu_req;
  logic       cpu_we;
  logic       cpu_bit;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       cpu_err;
  logic       hw_we;
  logic [6:0] hw_addr;
  logic [7:0] hw_wdata;
  logic [7:0] hw_wmask;
  logic       hw_collide;
  modport master (
    output cpu_req, cpu_we, cpu_bit, cpu_addr, cpu_wdata, hw_we, hw_addr, hw_wdata, hw_wmask,
    input  cpu_rdata, cpu_rvalid, cpu_err, hw_collide
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_bit, cpu_addr, cpu_wdata, hw_we, hw_addr, hw_wdata, hw_wmask,
    output cpu_rdata, cpu_rvalid, cpu_err, hw_collide
  );
endinterface

// File: rtl/sfr_bank.sv
// sfr_bank: 8051 SFR space 0x80-0xFF with byte/bit CPU access and masked hardware flag updates
module sfr_bank #(
  parameter logic [127:0] PRESENT_MASK = 128'h0001_0001_0001_0000_0101_0101_0301_3F8F,
  parameter logic [127:0] ONES_MASK    = 128'h0000_0000_0000_0000_0001_0001_0001_0001,
  parameter logic [6:0]   SP_OFFSET    = 7'h01,
  parameter logic [7:0]   SP_RESET     = 8'h07,
  parameter bit           BIT_EN       = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  sfr_bank_if.slave     bus,
  output logic [1023:0] sfr_flat
);
  function automatic logic [1023:0] reset_image();
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < 128; i++)
      if (PRESENT_MASK[i])
        v[8*i +: 8] = (i == int'(SP_OFFSET)) ? SP_RESET : (ONES_MASK[i] ? 8'hFF : 8'h00);
    return v;
  endfunction
  localparam logic [1023:0] RESET_IMAGE = reset_image();
  logic [1023:0] state, nxt;
  logic [6:0]    off;
  logic [2:0]    idx;
  logic          err, wr, rd, hw_ok, collide;
  logic [7:0]    cmask, cval, cur, hw_new, rdata;
  // decode the CPU request, classify errors and build the bit-level write mask
  always_comb begin
    off     = bus.cpu_bit ? {bus.cpu_addr[6:3], 3'b000} : bus.cpu_addr[6:0];
    idx     = bus.cpu_addr[2:0];
    err     = bus.cpu_req && (!bus.cpu_addr[7] || !PRESENT_MASK[off] || (bus.cpu_bit && !BIT_EN));
    wr      = bus.cpu_req && !err && bus.cpu_we;
    rd      = bus.cpu_req && !bus.cpu_we;
    cmask   = bus.cpu_bit ? (8'h01 << idx) : 8'hFF;
    cval    = bus.cpu_bit ? {8{bus.cpu_wdata[0]}} : bus.cpu_wdata;
    cur     = state[{off, 3'b000} +: 8];
    rdata   = err ? 8'h00 : (bus.cpu_bit ? {7'b0, cur[idx]} : cur);
    hw_ok   = bus.hw_we && PRESENT_MASK[bus.hw_addr];
    hw_new  = (state[{bus.hw_addr, 3'b000} +: 8] & ~bus.hw_wmask) | (bus.hw_wdata & bus.hw_wmask);
    collide = wr && hw_ok && (bus.hw_addr == off) && |(bus.hw_wmask & cmask);
  end
  // hardware merge lands first so a same-offset CPU write overrides only the bits it owns
  always_comb begin
    nxt = state;
    if (hw_ok) nxt[{bus.hw_addr, 3'b000} +: 8] = hw_new;
    if (wr) nxt[{off, 3'b000} +: 8] = (nxt[{off, 3'b000} +: 8] & ~cmask) | (cval & cmask);
  end
  // register file; absent bytes are never written so they hold their zero reset value
  always_ff @(posedge clk)
    state <= reset ? RESET_IMAGE : nxt;
  // registered response: read data sampled before this cycle's writes
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cpu_rdata  <= 8'h00;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_err    <= 1'b0;
      bus.hw_collide <= 1'b0;
    end else begin
      bus.cpu_rdata  <= rd ? rdata : bus.cpu_rdata;
      bus.cpu_rvalid <= rd;
      bus.cpu_err    <= err;
      bus.hw_collide <= collide;
    end
  end
  assign sfr_flat = state;
endmodule
